fetch_sequencer: RTL and testbench

- Sequences the power-gated instruction memory, which has a registered 1-cycle read and holds its output while its enable is low.
- Generates the fetch address and the memory enable, tracks which PC the held memory output belongs to, and handles stall, redirect, start/stop and address faults.
- Sits between the instruction memory and the IF/ID pipeline register.
- Memory enable is asserted only in cycles that perform a useful fetch.

---
 rtl/fetch_sequencer_if.sv | 53 +++++
 rtl/fetch_sequencer.sv | 162 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_if
//
// Bundles the signals between the fetch sequencer, the core control logic,
// the power-gated instruction memory and the IF/ID pipeline register.
//
//   master modport : the fetch sequencer itself
//   slave  modport : the surrounding core / memory / IF-ID register
//
// Signals
//   fetch_en          core run request (low = stop fetching, power idle)
//   stall             downstream not ready, hold the current instruction
//   redirect_valid    branch/jump/trap redirect this cycle
//   redirect_pc       redirect target byte address
//   imem_pc           address to memory
//   imem_enable       memory read enable
//   imem_instruction  memory output (registered inside the memory)
//   if_valid          if_pc / if_instruction hold a valid instruction
//   if_pc             PC of the instruction on imem_instruction
//   if_instruction    pass-through of imem_instruction
//   fault             fetch address fault pending
//   fault_pc          offending fetch address
//   active_cycles     cycles with the memory enabled (optional counter)
//   gated_cycles      non-reset cycles with the memory gated (optional)
// ----------------------------------------------------------------------------
interface fetch_sequencer_if;
   logic        fetch_en;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_pc;
   logic        imem_enable;
   logic [31:0] imem_instruction;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instruction;
   logic        fault;
   logic [31:0] fault_pc;
   logic [31:0] active_cycles;
   logic [31:0] gated_cycles;

   modport master (
      input  fetch_en, stall, redirect_valid, redirect_pc, imem_instruction,
      output imem_pc, imem_enable, if_valid, if_pc, if_instruction,
             fault, fault_pc, active_cycles, gated_cycles
   );

   modport slave (
      output fetch_en, stall, redirect_valid, redirect_pc, imem_instruction,
      input  imem_pc, imem_enable, if_valid, if_pc, if_instruction,
             fault, fault_pc, active_cycles, gated_cycles
   );
endinterface

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//
// Drives the power-gated instruction memory (registered 1-cycle read, output
// held while enable is low). Produces the fetch address and read enable,
// remembers which PC the held memory output belongs to, and handles stall,
// redirect, start/stop and address faults. The memory is only enabled in
// cycles that fetch something useful.
//
// Ports
//   clk    clock, all state updates on the rising edge
//   reset  synchronous active-high reset
//   bus    fetch_sequencer_if.master (see the interface file for signals)
//
// Parameters
//   RESET_PC   fetch address loaded on reset
//   MEM_BYTES  memory size in bytes; legal word address A has A+3 < MEM_BYTES
//   PC_STEP    sequential increment in bytes
//
// Build option
//   FETCH_ACTIVITY_COUNT_EN  when defined, active_cycles / gated_cycles are
//                            saturating activity counters; otherwise both
//                            outputs are tied to zero and no flops exist.
// ----------------------------------------------------------------------------
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_BYTES = 100,
   parameter int          PC_STEP   = 4
) (
   input logic                  clk,
   input logic                  reset,
   fetch_sequencer_if.master    bus
);

   localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
   localparam logic [31:0] STEP      = 32'(PC_STEP);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] fetch_pc;
   logic        resp_valid;
   logic [31:0] resp_pc;
   logic        fault_q;
   logic [31:0] fault_pc_q;

   logic [31:0] imem_pc_w;
   logic        want;
   logic        issue;
   logic        fault_trip;

   // Word-aligned and fully inside the memory (32-bit unsigned compare).
   function automatic logic addr_ok(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a <= LAST_WORD);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign imem_pc_w = bus.redirect_valid ? bus.redirect_pc : fetch_pc;

   // Issue decision. IDLE with fetch_en high behaves like RUN so that the
   // first fetch happens in the same cycle the core starts running.
   always_comb begin
      want       = bus.fetch_en && (bus.redirect_valid || !bus.stall);
      issue      = 1'b0;
      fault_trip = 1'b0;
      case (state)
         S_IDLE, S_RUN: begin
            issue      = want && addr_ok(imem_pc_w);
            fault_trip = want && !addr_ok(imem_pc_w);
         end
         S_FAULT: begin
            issue = bus.redirect_valid && bus.fetch_en && addr_ok(bus.redirect_pc);
         end
         default: begin
            issue      = 1'b0;
            fault_trip = 1'b0;
         end
      endcase
      if (reset) begin
         issue      = 1'b0;
         fault_trip = 1'b0;
      end
   end

   // Sequencer state, response tracking and fault capture
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         fetch_pc   <= RESET_PC;
         resp_valid <= 1'b0;
         resp_pc    <= 32'd0;
         fault_q    <= 1'b0;
         fault_pc_q <= 32'd0;
      end else begin
         // Start/stop transitions; overridden below by issue or fault.
         case (state)
            S_IDLE:  if (bus.fetch_en)  state <= S_RUN;
            S_RUN:   if (!bus.fetch_en) state <= S_IDLE;
            default: state <= state;
         endcase

         if (issue) begin
            state      <= S_RUN;
            resp_valid <= 1'b1;
            resp_pc    <= imem_pc_w;
            fetch_pc   <= imem_pc_w + STEP;
            fault_q    <= 1'b0;
         end else if (fault_trip) begin
            state      <= S_FAULT;
            resp_valid <= 1'b0;
            fault_q    <= 1'b1;
            fault_pc_q <= imem_pc_w;
            if (bus.redirect_valid) fetch_pc <= bus.redirect_pc;
         end else if (bus.redirect_valid) begin
            // Redirect that could not fetch: flush the stale instruction.
            resp_valid <= 1'b0;
            fetch_pc   <= bus.redirect_pc;
            if (state == S_FAULT && !addr_ok(bus.redirect_pc))
               fault_pc_q <= bus.redirect_pc;
         end
      end
   end

   assign bus.imem_pc        = imem_pc_w;
   assign bus.imem_enable    = issue;
   assign bus.if_valid       = resp_valid;
   assign bus.if_pc          = resp_pc;
   assign bus.if_instruction = bus.imem_instruction;
   assign bus.fault          = fault_q;
   assign bus.fault_pc       = fault_pc_q;

`ifdef FETCH_ACTIVITY_COUNT_EN
   logic [31:0] active_q;
   logic [31:0] gated_q;

   // Activity counters; reset cycles never count since issue is low in reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         active_q <= 32'd0;
         gated_q  <= 32'd0;
      end else if (issue) begin
         active_q <= sat_inc(active_q);
      end else begin
         gated_q  <= sat_inc(gated_q);
      end
   end

   assign bus.active_cycles = active_q;
   assign bus.gated_cycles  = gated_q;
`else
   assign bus.active_cycles = 32'd0;
   assign bus.gated_cycles  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer with a small registered instruction
// memory model (read on enable, output held otherwise).
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;
   logic [31:0] mem_q;

   fetch_sequencer_if bus();

   fetch_sequencer #(
      .RESET_PC  (32'h0000_0000),
      .MEM_BYTES (100),
      .PC_STEP   (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return (a == 32'd0) ? 32'h404002b7 : {16'hC0DE, a[15:0]};
   endfunction

   initial mem_q = 32'd0;
   always @(posedge clk) if (bus.imem_enable) mem_q <= rom(bus.imem_pc);
   assign bus.imem_instruction = mem_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock, then let registered values settle.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_act;
      logic [31:0] exp_gat;
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      bus.fetch_en = 1'b0;
      bus.stall = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'd0;

      // Reset state
      cyc(); cyc();
      check("rst_en",      {31'd0, bus.imem_enable}, 32'd0);
      check("rst_valid",   {31'd0, bus.if_valid}, 32'd0);
      check("rst_if_pc",   bus.if_pc, 32'd0);
      check("rst_fault",   {31'd0, bus.fault}, 32'd0);
      check("rst_fault_pc", bus.fault_pc, 32'd0);
      check("rst_active",  bus.active_cycles, 32'd0);
      check("rst_gated",   bus.gated_cycles, 32'd0);

      // Start fetching: first issue in the IDLE->RUN cycle
      reset = 1'b0; bus.fetch_en = 1'b1; #1;
      check("start_pc", bus.imem_pc, 32'd0);
      check("start_en", {31'd0, bus.imem_enable}, 32'd1);
      cyc();
      check("seq0_valid", {31'd0, bus.if_valid}, 32'd1);
      check("seq0_if_pc", bus.if_pc, 32'd0);
      check("seq0_instr", bus.if_instruction, 32'h404002b7);
      check("seq0_next",  bus.imem_pc, 32'd4);
      cyc();
      check("seq1_if_pc", bus.if_pc, 32'd4);
      check("seq1_next",  bus.imem_pc, 32'd8);
      cyc();
      check("seq2_if_pc", bus.if_pc, 32'd8);

      // Stall three cycles at if_pc=8
      bus.stall = 1'b1; #1;
      for (int i = 0; i < 3; i++) begin
         if (i != 0) cyc();
         check("stall_en",    {31'd0, bus.imem_enable}, 32'd0);
         check("stall_if_pc", bus.if_pc, 32'd8);
         check("stall_instr", bus.if_instruction, rom(32'd8));
      end
      cyc();
      bus.stall = 1'b0; #1;
      check("resume_pc", bus.imem_pc, 32'd12);
      check("resume_en", {31'd0, bus.imem_enable}, 32'd1);
      check("resume_if_pc", bus.if_pc, 32'd8);
      cyc();
      check("resume_if_pc2", bus.if_pc, 32'd12);

      // Redirect wins over stall
      bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd40; #1;
      check("redir_en", {31'd0, bus.imem_enable}, 32'd1);
      check("redir_pc", bus.imem_pc, 32'd40);
      cyc();
      bus.stall = 1'b0; bus.redirect_valid = 1'b0; #1;
      check("redir_if_pc", bus.if_pc, 32'd40);
      check("redir_valid", {31'd0, bus.if_valid}, 32'd1);
      check("redir_instr", bus.if_instruction, rom(32'd40));
      check("redir_next",  bus.imem_pc, 32'd44);

      // Run off the end of memory
      cyc();
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd76; #1;
      check("end_start", bus.imem_pc, 32'd76);
      cyc();
      bus.redirect_valid = 1'b0; #1;
      for (int k = 1; k <= 5; k++) begin
         if (k != 1) cyc();
         check("end_seq_pc", bus.imem_pc, 32'd76 + 32'(4 * k));
         check("end_seq_if", bus.if_pc, 32'd76 + 32'(4 * (k - 1)));
      end
      cyc();
      check("end_100_pc", bus.imem_pc, 32'd100);
      check("end_100_en", {31'd0, bus.imem_enable}, 32'd0);
      check("end_96_if",  bus.if_pc, 32'd96);
      cyc();
      check("end_fault",    {31'd0, bus.fault}, 32'd1);
      check("end_fault_pc", bus.fault_pc, 32'd100);
      check("end_valid",    {31'd0, bus.if_valid}, 32'd0);
      check("end_en",       {31'd0, bus.imem_enable}, 32'd0);
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd0; #1;
      check("recover_en", {31'd0, bus.imem_enable}, 32'd1);
      cyc();
      bus.redirect_valid = 1'b0; #1;
      check("recover_fault", {31'd0, bus.fault}, 32'd0);
      check("recover_if_pc", bus.if_pc, 32'd0);
      check("recover_valid", {31'd0, bus.if_valid}, 32'd1);
      check("recover_next",  bus.imem_pc, 32'd4);

      // Misaligned redirect target
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h6; #1;
      check("mis_en", {31'd0, bus.imem_enable}, 32'd0);
      cyc();
      bus.redirect_valid = 1'b0; #1;
      check("mis_fault",    {31'd0, bus.fault}, 32'd1);
      check("mis_fault_pc", bus.fault_pc, 32'd6);
      check("mis_valid",    {31'd0, bus.if_valid}, 32'd0);
      bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd20; #1;
      cyc();
      bus.redirect_valid = 1'b0; #1;
      check("mis_recover_if", bus.if_pc, 32'd20);

      // Stop and restart
      bus.fetch_en = 1'b0; #1;
      check("stop_en", {31'd0, bus.imem_enable}, 32'd0);
      cyc(); cyc();
      check("idle_en",    {31'd0, bus.imem_enable}, 32'd0);
      check("idle_if_pc", bus.if_pc, 32'd20);
      bus.fetch_en = 1'b1; #1;
      check("restart_pc", bus.imem_pc, 32'd24);
      check("restart_en", {31'd0, bus.imem_enable}, 32'd1);

      // Reset while stalled, then 10 issues + 5 stalled cycles
      cyc();
      bus.stall = 1'b1; reset = 1'b1; #1;
      check("rst_mid_en", {31'd0, bus.imem_enable}, 32'd0);
      cyc();
      check("rst_mid_valid", {31'd0, bus.if_valid}, 32'd0);
      check("rst_mid_if_pc", bus.if_pc, 32'd0);
      reset = 1'b0; bus.stall = 1'b0;
      repeat (10) cyc();
      bus.stall = 1'b1;
      repeat (5) cyc();
      check("cnt_if_pc", bus.if_pc, 32'd36);
`ifdef FETCH_ACTIVITY_COUNT_EN
      exp_act = 32'd10;
      exp_gat = 32'd5;
`else
      exp_act = 32'd0;
      exp_gat = 32'd0;
`endif
      check("cnt_active", bus.active_cycles, exp_act);
      check("cnt_gated",  bus.gated_cycles, exp_gat);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
